// File: rtl/apb_uart_pkg.sv
// Shared constants for the APB UART transmitter: register offsets, STATUS layout
// and serialiser state encoding.
package apb_uart_pkg;

    localparam logic [3:0] TXDATA_OFS  = 4'h0;
    localparam logic [3:0] STATUS_OFS  = 4'h4;
    localparam logic [3:0] BAUDDIV_OFS = 4'h8;
    localparam logic [3:0] CTRL_OFS    = 4'hC;

    localparam int unsigned STAT_FULL_BIT  = 0;
    localparam int unsigned STAT_EMPTY_BIT = 1;
    localparam int unsigned STAT_BUSY_BIT  = 2;
    localparam int unsigned STAT_LEVEL_LSB = 8;
    localparam int unsigned STAT_LEVEL_W   = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead output; pushes while full and pops while
// empty are ignored.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      level <= level + LW'(1);
            else if (do_pop && !do_push) level <= level - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/apb_uart_tx_slave.sv
// APB completer with a TX FIFO feeding an 8N1 UART serialiser; holds the
// register decode, control registers and the serialiser FSM.
module apb_uart_tx_slave
    import apb_uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned BAUD_DIV_RST = 16
) (
    input  logic        pclk,
    input  logic        Reset,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    input  logic [3:0]  pstrb,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic        tx,
    output logic        tx_busy
);
    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

    logic          access, wr_acc, rd_acc;
    logic [3:0]    reg_ofs;
    logic [15:0]   baud_div, eff_div;
    logic          tx_en;
    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]    fifo_dout;
    logic [LW-1:0] fifo_level;
    logic [31:0]   status_word;

    tx_state_t     state, state_nxt;
    logic [2:0]    bit_idx, bit_idx_nxt;
    logic [15:0]   baud_cnt, baud_cnt_nxt;
    logic [15:0]   bit_div, bit_div_nxt;
    logic [7:0]    shift, shift_nxt;
    logic          tx_nxt, bit_end, pop_ok;

    logic unused_bits;
    assign unused_bits = ^{paddr[31:4], paddr[1:0], pwdata[31:16], pstrb[3:2]};

    // APB outputs are combinational and forced low while Reset is held.
    assign access    = psel & penable & ~Reset;
    assign wr_acc    = access & pwrite;
    assign rd_acc    = access & ~pwrite;
    assign reg_ofs   = {paddr[3:2], 2'b00};
    assign pready    = access;
    assign fifo_push = wr_acc & (reg_ofs == TXDATA_OFS) & pstrb[0];
    assign pslverr   = wr_acc & (((reg_ofs == TXDATA_OFS) & pstrb[0] & fifo_full)
                                 | (reg_ofs == STATUS_OFS));

    always_comb begin
        status_word = '0;
        status_word[STAT_FULL_BIT]  = fifo_full;
        status_word[STAT_EMPTY_BIT] = fifo_empty;
        status_word[STAT_BUSY_BIT]  = tx_busy;
        status_word[STAT_LEVEL_LSB +: STAT_LEVEL_W] = STAT_LEVEL_W'(fifo_level);
    end

    always_comb begin
        prdata = '0;
        if (rd_acc) begin
            case (reg_ofs)
                STATUS_OFS:  prdata = status_word;
                BAUDDIV_OFS: prdata = {16'h0000, baud_div};
                CTRL_OFS:    prdata = {31'h0, tx_en};
                default:     prdata = '0;
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (Reset) begin
            baud_div <= 16'(BAUD_DIV_RST);
            tx_en    <= 1'b1;
        end else if (wr_acc) begin
            if (reg_ofs == BAUDDIV_OFS) begin
                if (pstrb[0]) baud_div[7:0]  <= pwdata[7:0];
                if (pstrb[1]) baud_div[15:8] <= pwdata[15:8];
            end
            if (reg_ofs == CTRL_OFS && pstrb[0]) tx_en <= pwdata[0];
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (pclk),
        .rst   (Reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (pwdata[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // A divisor of zero is treated as one; the divisor is latched per bit.
    assign eff_div = (baud_div == 16'd0) ? 16'd1 : baud_div;
    assign bit_end = (baud_cnt == bit_div - 16'd1);
    assign pop_ok  = tx_en & ~fifo_empty;

    always_comb begin
        state_nxt    = state;
        bit_idx_nxt  = bit_idx;
        baud_cnt_nxt = baud_cnt + 16'd1;
        bit_div_nxt  = bit_div;
        shift_nxt    = shift;
        fifo_pop     = 1'b0;
        tx_nxt       = 1'b1;
        case (state)
            ST_IDLE: begin
                baud_cnt_nxt = '0;
                if (pop_ok) begin
                    fifo_pop    = 1'b1;
                    shift_nxt   = fifo_dout;
                    state_nxt   = ST_START;
                    bit_idx_nxt = '0;
                    bit_div_nxt = eff_div;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_nxt    = ST_DATA;
                    baud_cnt_nxt = '0;
                    bit_idx_nxt  = '0;
                    bit_div_nxt  = eff_div;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    baud_cnt_nxt = '0;
                    bit_div_nxt  = eff_div;
                    if (bit_idx == 3'd7) state_nxt = ST_STOP;
                    else                 bit_idx_nxt = bit_idx + 3'd1;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    baud_cnt_nxt = '0;
                    if (pop_ok) begin
                        fifo_pop    = 1'b1;
                        shift_nxt   = fifo_dout;
                        state_nxt   = ST_START;
                        bit_idx_nxt = '0;
                        bit_div_nxt = eff_div;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        case (state_nxt)
            ST_START: tx_nxt = 1'b0;
            ST_DATA:  tx_nxt = shift_nxt[bit_idx_nxt];
            default:  tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (Reset) begin
            state    <= ST_IDLE;
            bit_idx  <= '0;
            baud_cnt <= '0;
            bit_div  <= 16'd1;
            shift    <= '0;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            state    <= state_nxt;
            bit_idx  <= bit_idx_nxt;
            baud_cnt <= baud_cnt_nxt;
            bit_div  <= bit_div_nxt;
            shift    <= shift_nxt;
            tx       <= tx_nxt;
            tx_busy  <= (state_nxt != ST_IDLE);
        end
    end

endmodule

// File: doc/apb_uart_tx_slave.md
# apb_uart_tx_slave

APB completer (slave 2 on the APB bus) that accepts bytes from the APB requester into a TX FIFO and serialises them onto a UART `tx` line as 8N1 frames. It is the responding end of the APB transfers the protocol master issues. Its registers provide data push, status readback, a baud divisor and a transmitter enable.

## Interface
Parameters:
- `FIFO_DEPTH`, 8: TX FIFO entries; power of two, 2 to 64.
- `BAUD_DIV_RST`, 16: reset value of the BAUDDIV register, in pclk cycles per bit.

Ports:
- `pclk`  in  1: single clock; all logic on its rising edge.
- `Reset`  in  1: synchronous reset, active-high.
- `psel`  in  1: slave select from the APB decoder.
- `penable`  in  1: access phase.
- `pwrite`  in  1: 1 = write, 0 = read.
- `paddr`  in  32: only `paddr[3:2]` is decoded. Upper bits and `[1:0]` are ignored.
- `pwdata`  in  32: write data.
- `pstrb`  in  4: byte strobes.
- `prdata`  out  32: read data. Reset value 0.
- `pready`  out  1: transfer complete. Reset value 0.
- `pslverr`  out  1: transfer error. Reset value 0.
- `tx`  out  1: UART serial output, idle high. Reset value 1.
- `tx_busy`  out  1: high when the serialiser FSM is not in IDLE. Reset value 0.

## Operation
**Register map**, selected by `paddr[3:2]`:
- 0x0 TXDATA (W): push `pwdata[7:0]` into the FIFO when `pstrb[0]` = 1. Reads return 0.
- 0x4 STATUS (R): bit0 = full, bit1 = empty, bit2 = `tx_busy`, bits[14:8] = FIFO level. All other bits are 0. Writes are ignored.
- 0x8 BAUDDIV (RW): bits[15:0]. Bytes 0 and 1 are written per `pstrb[0]` and `pstrb[1]`. Reset value is `BAUD_DIV_RST`. A stored value of 0 behaves as 1.
- 0xC CTRL (RW): bit0 = `tx_en`, reset value 1. It is written when `pstrb[0]` = 1.

**APB behaviour**
- Zero wait states: `pready` = `psel & penable`.
- An access completes in the cycle where `psel & penable & pready` are all high.
- `pslverr` is asserted only in that completing cycle, and only for:
  - a write to TXDATA while the FIFO is full (the byte is dropped);
  - a write to STATUS.
- `prdata` is driven combinationally during a read access phase. It is 0 otherwise.

**FIFO**
- Synchronous FIFO of `FIFO_DEPTH` bytes. Level width is `$clog2(FIFO_DEPTH)+1`.
- Read and write pointers wrap modulo `FIFO_DEPTH`.
- Push and pop in the same cycle leave the level unchanged.
- "Full" is evaluated before the edge. A push while full is rejected even if a pop happens in the same cycle.

**Serialiser FSM**: IDLE, START, DATA, STOP.
- IDLE → START when `tx_en` and the FIFO is not empty. The byte is popped and latched on that edge. The baud counter and bit index are cleared.
- START: `tx` = 0 for BAUDDIV cycles, then → DATA.
- DATA: drive `shift[bit_idx]`, LSB first. Each bit lasts BAUDDIV cycles. After bit 7 → STOP.
- STOP: `tx` = 1 for BAUDDIV cycles, then → IDLE. If the pop condition holds at the end of STOP, go directly to START with no idle gap (back-to-back frames).
- BAUDDIV is sampled when each bit period starts. A write to BAUDDIV mid-bit takes effect from the next bit.
- Clearing `tx_en` mid-frame finishes the current frame, then the FSM stays in IDLE.

## Timing
- A TXDATA write completing at edge N makes the FIFO non-empty after N.
- If the FSM is IDLE, the pop happens at edge N+1 and `tx` goes low from N+1.
- Frame length is exactly 10 × BAUDDIV cycles.
- STATUS reads reflect register state before the current edge.
- `Reset` asserted at any edge, including mid-frame or mid-access, produces the following after that edge:
  - `tx` = 1, FSM in IDLE;
  - FIFO empty, with pointers and level at 0;
  - registers at their reset values;
  - `pready`, `pslverr`, `prdata` = 0, even while `psel` and `penable` are high during reset.

## Structure
- Package `apb_uart_pkg`: register offsets (`TXDATA_OFS`, `STATUS_OFS`, `BAUDDIV_OFS`, `CTRL_OFS`), the STATUS bit positions, and the FSM state encoding.
- Sub-module `sync_fifo` (parameters WIDTH and DEPTH): push, pop, dout, full, empty, level. The top level holds the APB decode, registers and serialiser.

## Test plan
- Reset, then set BAUDDIV = 4 and write TXDATA = 0x41 → `tx` shows 0,1,0,0,0,0,0,1,0,1, each level held 4 cycles, 40 cycles total. `tx_busy` is high throughout.
- With `tx_en` = 0, write 8 bytes 0x00–0x07, then a 9th byte 0xFF → the 9th write gets `pslverr` = 1. STATUS reads 0x0000_0801 (full, level 8). After setting `tx_en`, exactly 8 frames are sent with no gaps.
- Read STATUS after reset → 0x0000_0002. Write BAUDDIV = 0x1234 with `pstrb` = 4'b0001 → reads back 0x0000_0034.
- Write STATUS → `pslverr` = 1 and STATUS is unchanged. Write TXDATA with `pstrb` = 4'b1110 → no push, `pslverr` = 0.
- Assert `Reset` during bit 3 of frame 0xA5 with 2 bytes queued → `tx` = 1 after the next edge, STATUS = 0x0000_0002, BAUDDIV = 16.
- Push and pop in the same cycle with level 3 → level stays 3, and the data order is preserved across pointer wrap-around.
